ofs_fim_eth_clk_toggle_monitor: RTL and testbench

- Multi-channel Ethernet clock activity monitor; the parametrised successor to the per-clock noprune keep-alive flops.
- Each monitored Ethernet clock domain supplies a free-running divide-by-2 toggle flop, built outside this block.
- This block runs on one system clock. It synchronises NUM_CH toggle inputs, counts their edges over a fixed measurement window, and reports per-channel edge counts, an alive flag and a sticky loss flag to the FIM CSR logic.
- The toggle sources have a live, non-prunable load through this block, so no separate noprune consumer is needed.

---
 rtl/ofs_fim_eth_clk_toggle_monitor.sv | 113 +++++++++++
 tb/tb_ofs_fim_eth_clk_toggle_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_eth_clk_toggle_monitor.sv
// Multi-channel Ethernet clock activity monitor.
// Each channel carries a divide-by-2 toggle from a remote clock domain. The
// toggle is synchronised into clk, its edges are counted over a fixed window,
// and at the end of every window the count, an alive flag and a sticky loss
// flag are published for the CSR logic.
module ofs_fim_eth_clk_toggle_monitor #(
   parameter int NUM_CH        = 4,
   parameter int WINDOW_CYCLES = 65536,
   parameter int CNT_W         = 16,
   parameter int MIN_EDGES     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       toggle_in,
   input  logic                    err_clear,
   output logic [NUM_CH*CNT_W-1:0] edge_cnt,
   output logic                    cnt_valid,
   output logic [NUM_CH-1:0]       clk_alive,
   output logic [NUM_CH-1:0]       clk_lost_sticky
);

   localparam int               WIN_W       = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] MIN_EDGES_C = CNT_W'(MIN_EDGES);

   logic [NUM_CH-1:0]       sync1_q, sync2_q, sync3_q;
   logic [NUM_CH-1:0]       edge_det;
   logic [WIN_W-1:0]        win_q, win_d;
   logic                    win_last, capture;
   logic [CNT_W-1:0]        run_q   [NUM_CH];
   logic [CNT_W-1:0]        run_d   [NUM_CH];
   logic [CNT_W-1:0]        run_inc [NUM_CH];
   logic [NUM_CH-1:0]       alive_new;
   logic [NUM_CH*CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic                    cnt_valid_q, cnt_valid_d;
   logic [NUM_CH-1:0]       alive_q, alive_d;
   logic [NUM_CH-1:0]       sticky_q, sticky_d;

   // s2 is the first metastability-safe stage; s3 is its one-cycle history.
   assign edge_det = sync2_q ^ sync3_q;

   // Synchronisers keep sampling even while disabled so re-enable starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= toggle_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Window counter, running counters and published results (next-state).
   always_comb begin
      win_last    = (win_q == WIN_LAST);
      capture     = enable && win_last;
      win_d       = '0;
      edge_cnt_d  = edge_cnt_q;
      cnt_valid_d = capture;
      alive_new   = '0;
      if (enable && !win_last) begin
         win_d = win_q + WIN_W'(1);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         // Saturating increment; the terminal cycle's own edge is included.
         run_inc[i] = run_q[i];
         if (edge_det[i] && (run_q[i] != CNT_MAX)) begin
            run_inc[i] = run_q[i] + CNT_W'(1);
         end
         run_d[i]     = (enable && !win_last) ? run_inc[i] : '0;
         alive_new[i] = (run_inc[i] >= MIN_EDGES_C);
         if (capture) begin
            edge_cnt_d[i*CNT_W +: CNT_W] = run_inc[i];
         end
      end
      alive_d  = capture ? alive_new : alive_q;
      // A loss detected on capture wins over a simultaneous clear.
      sticky_d = (sticky_q & ~{NUM_CH{err_clear}}) | (capture ? ~alive_new : '0);
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q       <= '0;
         edge_cnt_q  <= '0;
         cnt_valid_q <= 1'b0;
         alive_q     <= '0;
         sticky_q    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            run_q[i] <= '0;
         end
      end else begin
         win_q       <= win_d;
         edge_cnt_q  <= edge_cnt_d;
         cnt_valid_q <= cnt_valid_d;
         alive_q     <= alive_d;
         sticky_q    <= sticky_d;
         for (int i = 0; i < NUM_CH; i++) begin
            run_q[i] <= run_d[i];
         end
      end
   end

   assign edge_cnt        = edge_cnt_q;
   assign cnt_valid       = cnt_valid_q;
   assign clk_alive       = alive_q;
   assign clk_lost_sticky = sticky_q;

endmodule

// File: tb/tb_ofs_fim_eth_clk_toggle_monitor.sv
// Directed bench for the Ethernet clock toggle monitor: window timing,
// alive/loss flags, saturation, enable gaps, reset and the sync boundary.
module tb_ofs_fim_eth_clk_toggle_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        err_clear = 1'b0;
   logic        tog0 = 1'b0;
   logic        tog2 = 1'b0;
   logic        tog_b = 1'b0;
   logic        ch0_en = 1'b0;
   logic        b_en = 1'b0;
   int          ph = 0;

   logic [31:0] edge_cnt;
   logic        cnt_valid;
   logic [3:0]  clk_alive;
   logic [3:0]  clk_lost_sticky;

   logic [15:0] edge_cnt_b;
   logic        cnt_valid_b;
   logic [3:0]  clk_alive_b;
   logic [3:0]  clk_lost_sticky_b;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n;
   int          gap_valids;

   ofs_fim_eth_clk_toggle_monitor #(
      .NUM_CH(4), .WINDOW_CYCLES(64), .CNT_W(8), .MIN_EDGES(4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .toggle_in       ({1'b0, tog2, 1'b0, tog0}),
      .err_clear       (err_clear),
      .edge_cnt        (edge_cnt),
      .cnt_valid       (cnt_valid),
      .clk_alive       (clk_alive),
      .clk_lost_sticky (clk_lost_sticky)
   );

   ofs_fim_eth_clk_toggle_monitor #(
      .NUM_CH(4), .WINDOW_CYCLES(64), .CNT_W(4), .MIN_EDGES(4)
   ) dut_b (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .toggle_in       ({3'b000, tog_b}),
      .err_clear       (err_clear),
      .edge_cnt        (edge_cnt_b),
      .cnt_valid       (cnt_valid_b),
      .clk_alive       (clk_alive_b),
      .clk_lost_sticky (clk_lost_sticky_b)
   );

   always #5 clk = ~clk;

   // Toggle sources: ch0 flips every 4 clk, dut_b ch0 every 2 clk.
   initial forever begin
      @(posedge clk);
      #2;
      ph++;
      if (ch0_en && (ph % 4 == 0)) tog0 = ~tog0;
      if (b_en && (ph % 2 == 0)) tog_b = ~tog_b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits for the next cnt_valid (sampled on negedge); returns posedges waited.
   task automatic wait_valid(input string tag, output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end while (!cnt_valid && cycles < 300);
      chk(tag, 32'(cnt_valid), 32'd1);
   endtask

   function automatic logic [31:0] near16(input logic [7:0] v);
      return (v >= 8'd15 && v <= 8'd17) ? 32'd1 : 32'd0;
   endfunction

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_edge_cnt",  edge_cnt, 32'h0);
      chk("rst_cnt_valid", 32'(cnt_valid), 32'd0);
      chk("rst_alive",     32'(clk_alive), 32'h0);
      chk("rst_sticky",    32'(clk_lost_sticky), 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Window 1: ch0 toggling every 4 cycles, others quiet
      @(posedge clk); #1;
      enable = 1'b1;
      ch0_en = 1'b1;
      b_en   = 1'b1;
      wait_valid("w1_valid", n);
      chk("w1_latency",  32'(n), 32'd64);
      chk("w1_cnt0",     near16(edge_cnt[7:0]), 32'd1);
      chk("w1_cnt123",   32'(edge_cnt[31:8]), 32'h0);
      chk("w1_alive",    32'(clk_alive), 32'h1);
      chk("w1_sticky",   32'(clk_lost_sticky), 32'he);
      chk("sat_cnt0",    32'(edge_cnt_b[3:0]), 32'd15);
      chk("sat_alive0",  32'(clk_alive_b[0]), 32'd1);
      @(posedge clk); @(negedge clk);
      chk("w1_valid_pulse", 32'(cnt_valid), 32'd0);

      // Window 2: still alive, period unchanged
      wait_valid("w2_valid", n);
      chk("w2_latency", 32'(n), 32'd63);
      chk("w2_alive",   32'(clk_alive), 32'h1);
      chk("w2_cnt0",    near16(edge_cnt[7:0]), 32'd1);

      // Enable gap starting at win=30 for 100 cycles
      repeat (30) @(posedge clk);
      #1 enable = 1'b0;
      gap_valids = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); @(negedge clk);
         if (cnt_valid) gap_valids++;
      end
      chk("gap_no_valid", 32'(gap_valids), 32'd0);
      chk("gap_alive",    32'(clk_alive), 32'h1);
      chk("gap_sticky",   32'(clk_lost_sticky), 32'he);
      chk("gap_cnt0",     near16(edge_cnt[7:0]), 32'd1);
      @(posedge clk); #1 enable = 1'b1;
      wait_valid("regap_valid", n);
      chk("regap_latency", 32'(n), 32'd64);
      chk("regap_cnt0",    near16(edge_cnt[7:0]), 32'd1);

      // ch0 stops: loss on the next capture
      ch0_en = 1'b0;
      wait_valid("lost_valid", n);
      chk("lost_alive",  32'(clk_alive), 32'h0);
      chk("lost_sticky", 32'(clk_lost_sticky), 32'hf);

      // err_clear away from a capture clears, next capture re-sets
      repeat (10) @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk); #1 err_clear = 1'b0;
      @(negedge clk);
      chk("clr_sticky", 32'(clk_lost_sticky), 32'h0);
      wait_valid("reset_valid", n);
      chk("reset_sticky", 32'(clk_lost_sticky), 32'hf);

      // err_clear coincident with the terminal cycle: set wins
      repeat (63) @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk); #1 err_clear = 1'b0;
      @(negedge clk);
      chk("coinc_valid",  32'(cnt_valid), 32'd1);
      chk("coinc_sticky", 32'(clk_lost_sticky), 32'hf);

      // ch2 single transition at win=61: lands in the current window
      repeat (61) @(posedge clk);
      #1 tog2 = ~tog2;
      wait_valid("w61_valid", n);
      chk("w61_cnt2", 32'(edge_cnt[23:16]), 32'd1);

      // ch2 single transition at win=62: lands in the next window
      repeat (62) @(posedge clk);
      #1 tog2 = ~tog2;
      wait_valid("w62_valid_a", n);
      chk("w62_cnt2_cur", 32'(edge_cnt[23:16]), 32'd0);
      wait_valid("w62_valid_b", n);
      chk("w62_cnt2_next", 32'(edge_cnt[23:16]), 32'd1);

      // Asynchronous reset mid-window with ch0 toggling
      ch0_en = 1'b1;
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_edge_cnt",  edge_cnt, 32'h0);
      chk("arst_cnt_valid", 32'(cnt_valid), 32'd0);
      chk("arst_alive",     32'(clk_alive), 32'h0);
      chk("arst_sticky",    32'(clk_lost_sticky), 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      wait_valid("post_rst_valid", n);
      chk("post_rst_latency", 32'(n), 32'd64);
      chk("post_rst_cnt0",    near16(edge_cnt[7:0]), 32'd1);
      chk("post_rst_alive",   32'(clk_alive), 32'h1);
      chk("post_rst_sticky",  32'(clk_lost_sticky), 32'he);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
